keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives and scans a 4x4 matrix keypad (Pmod KYPD style): column strobes out, row senses in.
//  Debounces each press and emits one 4-bit key code with a one-cycle load strobe.
//  The key/ld pair feeds the 4-bit load register in front of the MCU input port.
//  Applies n-key lockout: one key per press, and no new code until full release.
// PARAMETERS
//  SCAN_DIV        100_000  clocks each column is driven (dwell); must be >= 4
//  DEBOUNCE_SCANS  4        consecutive identical full scans needed to accept a press or a release
//  REPEAT_DELAY    50       scans held before the first auto-repeat (KEY_REPEAT_EN only)
//  REPEAT_RATE     10       scans between later auto-repeats (KEY_REPEAT_EN only)
// PORTS
//  clk       in   1  system clock
//  clr       in   1  synchronous active-high reset
//  rows_n    in   4  keypad row senses, active-low, asynchronous (external pull-ups)
//  col_n     out  4  column strobes, active-low, exactly one bit low at a time
//  ld        out  1  one-cycle pulse: key is a new accepted code
//  key       out  4  accepted key code; held stable until the next ld
//  key_held  out  1  high while the accepted key is considered pressed
// BEHAVIOUR
//  Reset (clr=1 at posedge): col_n=4'b1110, ld=0, key=0, key_held=0, FSM=IDLE, all counters 0.
//   Reset mid-press or mid-debounce discards all progress; no ld on the cycle after reset.
//  rows_n passes through a 2-FF synchronizer. Dwell counter runs 0..SCAN_DIV-1 per column.
//   Sample synced rows at count SCAN_DIV-1, then advance column 0->1->2->3->0 (wraps).
//   One full scan = 4*SCAN_DIV clocks; a scan ends at the column-3 sample.
//  Scan result: NONE (no row low), SINGLE(r,c) (exactly one row/col hit), MULTI (anything else).
//   Code = KEY_MAP[r][c]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D.
//  FSM is evaluated only at scan end:
//   IDLE:     SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. NONE or MULTI -> stay.
//   DEBOUNCE: SINGLE(cand) -> cnt++. At cnt==DEBOUNCE_SCANS -> PRESSED, key=cand, ld=1 for one clk.
//             Other result -> IDLE, cnt=0.
//   PRESSED:  key_held=1. NONE -> RELEASE, cnt=1. SINGLE or MULTI -> stay, no new ld (lockout).
//   RELEASE:  key_held stays 1. NONE -> cnt++; at cnt==DEBOUNCE_SCANS -> IDLE, key_held=0.
//             Any key -> PRESSED, cnt=0, no ld.
//  Latency: ld is asserted in the clock after the DEBOUNCE_SCANS-th confirming scan end.
//   ld and the new key value change in the same cycle.
//  DEBOUNCE_SCANS=1 accepts on the first SINGLE scan (IDLE->PRESSED directly).
// CONFIGURATION
//  KEY_REPEAT_EN defined: in PRESSED, a scan counter counts held scans (SINGLE(key) only).
//   At REPEAT_DELAY it pulses ld, same key; afterwards it pulses ld every REPEAT_RATE scans.
//   The counter clears on leaving PRESSED.
//  KEY_REPEAT_EN undefined: exactly one ld per press; the REPEAT_* parameters are ignored.
// STRUCTURE
//  Package keypad_pkg: state enum (IDLE, DEBOUNCE, PRESSED, RELEASE).
//   Also holds the scan-result enum, KEY_MAP constant, and NUM_COLS/NUM_ROWS = 4.
//  Sub-module keypad_sync: 4-bit two-flop synchronizer for rows_n, reset value 4'b1111.
//  Dwell counter, column ring, result classifier and FSM live in keypad_scanner.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=8, REPEAT_RATE=4; scan = 16 clk)
//  1 Reset: clr=1 for 2 clk.
//    -> col_n=1110, ld=0, key=0, key_held=0. Column walks 1110,1101,1011,0111 every 4 clk.
//  2 Hold r1/c2 low for 30 scans.
//    -> exactly one ld with key=4'h6 after the 3rd scan end. key_held=1. Macro off: no further ld.
//  3 Bounce: r1/c2 for 1 scan, release 1 scan, then steady.
//    -> no ld until 3 consecutive SINGLE scans, then one ld key=6.
//  4 Press r0/c0 and r3/c3 together -> no ld. Then press 5, add 9 while held -> one ld key=5 only.
//    Release all -> key_held=0 after 3 NONE scans.
//  5 clr pulse during DEBOUNCE (cnt=2) -> no ld. A fresh 3-scan press is required for ld.
//  6 KEY_REPEAT_EN defined, hold key A for 20 scans.
//    -> ld at scan 3, then 11, 15, 19. All with key=4'hA.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
//   state_e     : press-tracking FSM states
//   scan_res_e  : classification of one complete four-column scan
//   KEY_MAP     : key code for each (row, column) crossing
//   NUM_ROWS / NUM_COLS : matrix dimensions
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_e;

    // Indexed [row][column]; matches the Pmod KYPD legend.
    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

endpackage

// File: rtl/keypad_if.sv
// Bundle between the scanner, the keypad matrix and the key load register.
//   rows_n   : row senses, active-low (keypad -> scanner)
//   col_n    : column strobes, active-low, one-hot-low (scanner -> keypad)
//   ld       : one-cycle load strobe (scanner -> load register)
//   key      : accepted key code (scanner -> load register)
//   key_held : accepted key still considered pressed (scanner -> consumer)
//
// Load handshake: there is no ready; the consumer must capture key on every
// cycle where ld is high. ld is high for exactly one clock per accepted code,
// key changes only in the same cycle ld rises and is stable until the next ld.
interface keypad_if;
    logic [3:0] rows_n;
    logic [3:0] col_n;
    logic       ld;
    logic [3:0] key;
    logic       key_held;

    modport master (
        input  rows_n,
        output col_n,
        output ld,
        output key,
        output key_held
    );

    modport slave (
        output rows_n,
        input  col_n,
        input  ld,
        input  key,
        input  key_held
    );
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous active-low row senses.
//   clk : system clock
//   clr : synchronous active-high reset (flops return to 4'b1111 = no row low)
//   d   : raw row senses
//   q   : synchronized row senses
module keypad_sync (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (clr) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and n-key lockout.
// Walks an active-low column strobe, samples the synchronized rows at the
// end of each column dwell, classifies every full scan as NONE / SINGLE /
// MULTI, and runs a press FSM at each scan end that emits one key code with
// a one-cycle ld strobe per accepted press.
//   clk       : system clock
//   clr       : synchronous active-high reset
//   kp        : keypad_if master (rows_n in; col_n, ld, key, key_held out)
//   dbg_state : current press FSM state
// Optional feature: define KEY_REPEAT_EN to re-pulse ld while a key is held
// (first after REPEAT_DELAY held scans, then every REPEAT_RATE scans).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic     clk,
    input  logic     clr,
    keypad_if.master kp,
    output state_e   dbg_state
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Debounce and repeat counters share one width, sized for the largest limit.
    localparam int CNT_MAX0 = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_MAX  = (DEBOUNCE_SCANS > CNT_MAX0) ? DEBOUNCE_SCANS : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    // ---------------- row synchronizer ----------------
    logic [3:0] rows_s;

    keypad_sync u_sync (
        .clk (clk),
        .clr (clr),
        .d   (kp.rows_n),
        .q   (rows_s)
    );

    // ---------------- dwell counter and column ring ----------------
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          sample;
    logic          scan_end;

    assign sample   = (dwell == DW'(SCAN_DIV - 1));
    assign scan_end = sample && (col_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (clr) begin
            dwell   <= '0;
            col_idx <= 2'd0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign kp.col_n = ~(4'b0001 << col_idx);

    // ---------------- scan classifier ----------------
    // Hits are accumulated column by column, saturating at 2 (= MULTI).
    // Column 0 starts a fresh scan, so the accumulator is ignored there.
    logic [1:0] acc_hits, acc_row, acc_col;
    logic [1:0] base_hits;
    logic [1:0] m_hits, m_row, m_col;
    logic [1:0] hit_row;
    logic [3:0] row_hit;
    scan_res_e  scan_res;
    logic [3:0] scan_code;

    always_comb begin
        row_hit   = ~rows_s;
        base_hits = (col_idx == 2'd0) ? 2'd0 : acc_hits;
        hit_row   = 2'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_hit[r]) hit_row = 2'(r);
        end

        m_hits = base_hits;
        m_row  = acc_row;
        m_col  = acc_col;
        if (row_hit != 4'b0000) begin
            if ($onehot(row_hit) && (base_hits == 2'd0)) begin
                m_hits = 2'd1;
                m_row  = hit_row;
                m_col  = col_idx;
            end else begin
                m_hits = 2'd2;
            end
        end

        case (m_hits)
            2'd0:    scan_res = RES_NONE;
            2'd1:    scan_res = RES_SINGLE;
            default: scan_res = RES_MULTI;
        endcase
        scan_code = KEY_MAP[m_row][m_col];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_hits <= 2'd0;
            acc_row  <= 2'd0;
            acc_col  <= 2'd0;
        end else if (sample) begin
            acc_hits <= m_hits;
            acc_row  <= m_row;
            acc_col  <= m_col;
        end
    end

    // ---------------- press FSM ----------------
    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       cand, cand_n;
    logic [3:0]       key, key_n;
    logic             ld, ld_n;
    logic             single_cand;

    assign cnt_inc     = cnt + CNT_W'(1);
    assign single_cand = (scan_res == RES_SINGLE) && (scan_code == cand);

`ifdef KEY_REPEAT_EN
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n, rep_inc, rep_target;
    logic             rep_started, rep_started_n;

    assign rep_inc    = rep_cnt + CNT_W'(1);
    assign rep_target = rep_started ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);

    always_ff @(posedge clk) begin
        if (clr) begin
            rep_cnt     <= '0;
            rep_started <= 1'b0;
        end else begin
            rep_cnt     <= rep_cnt_n;
            rep_started <= rep_started_n;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'h0;
            key   <= 4'h0;
            ld    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cand  <= cand_n;
            key   <= key_n;
            ld    <= ld_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        key_n   = key;
        ld_n    = 1'b0;
`ifdef KEY_REPEAT_EN
        // Repeat tracking only survives while PRESSED.
        rep_cnt_n     = (state == PRESSED) ? rep_cnt : '0;
        rep_started_n = (state == PRESSED) ? rep_started : 1'b0;
`endif
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_res == RES_SINGLE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = PRESSED;
                            key_n   = scan_code;
                            ld_n    = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            state_n = DEBOUNCE;
                            cand_n  = scan_code;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (single_cand) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n = PRESSED;
                            key_n   = cand;
                            ld_n    = 1'b1;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    // Lockout: SINGLE or MULTI keeps us here without a new code.
                    if (scan_res == RES_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = CNT_W'(1);
                        end
`ifdef KEY_REPEAT_EN
                        rep_cnt_n     = '0;
                        rep_started_n = 1'b0;
                    end else if ((scan_res == RES_SINGLE) && (scan_code == key)) begin
                        if (rep_inc == rep_target) begin
                            ld_n          = 1'b1;
                            rep_cnt_n     = '0;
                            rep_started_n = 1'b1;
                        end else begin
                            rep_cnt_n = rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (scan_res == RES_NONE) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n = IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // Contact bounce during release: back to held, no new code.
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign kp.ld       = ld;
    assign kp.key      = key;
    assign kp.key_held = (state == PRESSED) || (state == RELEASE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3,
// REPEAT_DELAY=8, REPEAT_RATE=4 (one scan = 16 clocks). A behavioural keypad
// pulls rows low for pressed keys in the driven column. Expected ld codes go
// into exp_q when a stimulus segment is driven; a monitor pops on every ld.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD        = 4;
    localparam int DS        = 3;
    localparam int RD        = 8;
    localparam int RR        = 4;
    localparam int SCAN_CLKS = 4 * SD;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    keypad_if kp();
    state_e   dbg_state;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .kp        (kp.master),
        .dbg_state (dbg_state)
    );

    // ---------------- keypad model ----------------
    logic [15:0] pressed = '0;   // bit r*4+c
    logic [3:0]  rows_model;

    always_comb begin
        rows_model = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_n[c]) rows_model[r] = 1'b0;
    end
    assign kp.rows_n = rows_model;

    logic [3:0] tb_map [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [15:0] kbit(int r, int c);
        logic [15:0] m;
        m = '0;
        m[r*4+c] = 1'b1;
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic [3:0] last_key = 4'h0;
    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (kp.ld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ld: got ld=1 key=%0h expected no ld at %0t", kp.key, $time);
            end else begin
                check("ld_key", 32'(kp.key), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver ----------------
    typedef struct {
        logic [15:0] keys;
        int          scans;
        bit          has_ld;
        logic [3:0]  ld_key;
        bit          held;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic [15:0] keys, int scans, bit has_ld, logic [3:0] ld_key, bit held);
        vec_t v;
        v.keys = keys; v.scans = scans; v.has_ld = has_ld; v.ld_key = ld_key; v.held = held;
        vecs.push_back(v);
    endtask

    // Segments start 3 time units after a scan-end edge and last whole scans.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            pressed = vecs[i].keys;
            if (vecs[i].has_ld) begin
                exp_q.push_back(vecs[i].ld_key);
                last_key = vecs[i].ld_key;
            end
            repeat (SCAN_CLKS * vecs[i].scans) @(posedge clk);
            #3;
            check("key_held", 32'(kp.key_held), 32'(vecs[i].held));
            check("key", 32'(kp.key), 32'(last_key));
            check("pending_ld", 32'(exp_q.size()), 32'd0);
        end
        vecs.delete();
    endtask

    task automatic do_reset(int cycles);
        clr = 1'b1;
        repeat (cycles) @(posedge clk);
        #3;
        clr = 1'b0;
        exp_q.delete();
        last_key = 4'h0;
        check("rst_col_n", 32'(kp.col_n), 32'h0000000E);
        check("rst_ld", 32'(kp.ld), 32'd0);
        check("rst_key", 32'(kp.key), 32'd0);
        check("rst_key_held", 32'(kp.key_held), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- tests ----------------
    initial begin
        logic [3:0] exp_col;
        int r, c;

        // 1: reset and column walk
        pressed = '0;
        do_reset(2);
        for (int i = 1; i <= SCAN_CLKS; i++) begin
            @(posedge clk);
            #1;
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check("col_walk", 32'(kp.col_n), 32'(exp_col));
        end

        // 2: steady press of 6 (r1/c2), then release
        do_reset(2);
        add(kbit(1,2), 2, 0, 4'h0, 0);
        add(kbit(1,2), 1, 1, 4'h6, 1);
`ifndef KEY_REPEAT_EN
        add(kbit(1,2), 27, 0, 4'h0, 1);
`else
        add(kbit(1,2), 4, 0, 4'h0, 1);
`endif
        add('0, 2, 0, 4'h0, 1);
        add('0, 1, 0, 4'h0, 0);
        run_vecs();

        // 3: bounce then steady
        add(kbit(1,2), 1, 0, 4'h0, 0);
        add('0, 1, 0, 4'h0, 0);
        add(kbit(1,2), 2, 0, 4'h0, 0);
        add(kbit(1,2), 1, 1, 4'h6, 1);
        add('0, 3, 0, 4'h0, 0);
        run_vecs();

        // 4: multi-key, lockout, release bounce, same-column multi
        add(kbit(0,0) | kbit(3,3), 4, 0, 4'h0, 0);
        add(kbit(1,0) | kbit(2,0), 3, 0, 4'h0, 0);
        add(kbit(1,1), 2, 0, 4'h0, 0);
        add(kbit(1,1), 1, 1, 4'h5, 1);
        add(kbit(1,1) | kbit(2,2), 5, 0, 4'h0, 1);
        add(kbit(2,2), 2, 0, 4'h0, 1);
        add('0, 1, 0, 4'h0, 1);
        add(kbit(1,1), 2, 0, 4'h0, 1);
        add('0, 2, 0, 4'h0, 1);
        add('0, 1, 0, 4'h0, 0);
        run_vecs();

        // 5: clr pulse while debouncing (cnt=2)
        add(kbit(1,2), 2, 0, 4'h0, 0);
        run_vecs();
        check("state_debounce", 32'(dbg_state), 32'(DEBOUNCE));
        do_reset(1);
        add(kbit(1,2), 2, 0, 4'h0, 0);
        add(kbit(1,2), 1, 1, 4'h6, 1);
        add('0, 3, 0, 4'h0, 0);
        run_vecs();

        // random single keys
        for (int n = 0; n < 6; n++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            add(kbit(r,c), 2, 0, 4'h0, 0);
            add(kbit(r,c), 1, 1, tb_map[r][c], 1);
            add('0, 3, 0, 4'h0, 0);
            run_vecs();
        end

`ifdef KEY_REPEAT_EN
        // 6: auto-repeat on A (r0/c3): ld at scans 3, 11, 15, 19
        do_reset(2);
        add(kbit(0,3), 2, 0, 4'h0, 0);
        add(kbit(0,3), 1, 1, 4'hA, 1);
        add(kbit(0,3), 7, 0, 4'h0, 1);
        add(kbit(0,3), 1, 1, 4'hA, 1);
        add(kbit(0,3), 3, 0, 4'h0, 1);
        add(kbit(0,3), 1, 1, 4'hA, 1);
        add(kbit(0,3), 3, 0, 4'h0, 1);
        add(kbit(0,3), 1, 1, 4'hA, 1);
        add(kbit(0,3), 1, 0, 4'h0, 1);
        add('0, 3, 0, 4'h0, 0);
        run_vecs();
`endif

        repeat (4) @(posedge clk);
        #3;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL timeout: got no end of test expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
